// File: rtl/shift_reg_sipo_buf.sv
// shift_reg_sipo_buf: serial-in parallel-out word assembler with a one-word valid/ready output buffer
module shift_reg_sipo_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             data_in,
  input  logic             clear,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_word;
  logic             w_cap, w_last, w_load, w_take;
  assign w_cap  = shift_en & ~clear;
  assign w_last = w_cap && (r_cnt == CW'(WIDTH - 1));
  assign w_word = {r_sr[WIDTH-2:0], data_in};
  assign w_take = data_valid & data_ready;
  assign w_load = w_last & (~data_valid | data_ready);
  assign busy   = (r_state == SHIFT);
  // next assembly state: clear wins, a completing capture returns to IDLE
  always_comb begin
    w_state_nxt = clear ? IDLE : w_cap ? (w_last ? IDLE : SHIFT) : r_state;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end
  // shift register and bit counter; counter wraps explicitly for non-power-of-two widths
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (shift_en) begin
      r_sr  <= w_word;
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end
  // output buffer: a completed word loads when the slot is free or being accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (w_load) begin
      data_out   <= w_word;
      data_valid <= 1'b1;
    end else if (w_take) begin
      data_valid <= 1'b0;
    end
  end
  // sticky overrun: set when a completed word finds the buffer full and not accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   overrun <= 1'b0;
    else if (clear)                               overrun <= 1'b0;
    else if (w_last & data_valid & ~data_ready)   overrun <= 1'b1;
  end
endmodule
